// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory port arbiter: response-pipe stage record, index width helper, counter width.
package mem_port_arb_pkg;

  localparam int PerfCntWidth = 16;
  localparam int MaxIdxWidth  = 8;

  typedef logic [MaxIdxWidth-1:0] rsp_idx_t;

  typedef struct packed {
    logic     valid;
    rsp_idx_t idx;
  } rsp_stage_t;

  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle of the memory port arbiter; signal directions named from the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  localparam int IdxWidth = mem_port_arb_pkg::idx_width(NumPorts);
  localparam int BeWidth  = DataWidth / 8;

  logic [NumPorts-1:0]           req_i;
  logic [NumPorts-1:0]           gnt_o;
  logic [NumPorts*AddrWidth-1:0] addr_i;
  logic [NumPorts-1:0]           we_i;
  logic [NumPorts*DataWidth-1:0] wdata_i;
  logic [NumPorts*BeWidth-1:0]   be_i;
  logic [NumPorts-1:0]           rvalid_o;
  logic [DataWidth-1:0]          rdata_o;
  logic                          mem_req_o;
  logic                          mem_gnt_i;
  logic [AddrWidth-1:0]          mem_addr_o;
  logic                          mem_we_o;
  logic [DataWidth-1:0]          mem_wdata_o;
  logic [BeWidth-1:0]            mem_be_o;
  logic [DataWidth-1:0]          mem_rdata_i;
  logic [IdxWidth-1:0]           idx_o;

  modport slave (
    input  req_i, addr_i, we_i, wdata_i, be_i, mem_gnt_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o, idx_o
  );

  modport master (
    output req_i, addr_i, we_i, wdata_i, be_i, mem_gnt_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o, idx_o
  );

endinterface

// File: rtl/mem_port_arb_rsp_pipe.sv
// Fixed-latency delay line of {valid, idx} response records; Latency cycles, no backpressure.
module mem_port_arb_rsp_pipe
  import mem_port_arb_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  rsp_stage_t stage_i,
  output rsp_stage_t stage_o
);

  rsp_stage_t stage_q [Latency];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= stage_i;
      for (int i = 1; i < Latency; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign stage_o = stage_q[Latency-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one SRAM port; combinational request path, grant held while memory stalls, responses after MemLatency.
// Optional per-port saturating grant counters under MEM_PORT_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int NumPorts   = 4,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int MemLatency = 1,
  parameter int IdxWidth   = idx_width(NumPorts)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  mem_port_arbiter_if.slave bus
`ifdef MEM_PORT_ARB_PERF_CNT_EN
  ,
  output logic [NumPorts*PerfCntWidth-1:0] grant_cnt_o
`endif
);

  localparam int BeWidth = DataWidth / 8;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumPorts - 1);

  logic [IdxWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, rr_idx, win_idx;
  logic                lock_q, lock_d, lock_hit, mem_req, xfer;
  logic [NumPorts-1:0] gnt, rvalid;
  rsp_stage_t          rsp_in, rsp_out;

  // Second pass overrides the wrap-around choice whenever a port above rr_q is requesting.
  always_comb begin
    rr_idx = '0;
    for (int i = NumPorts-1; i >= 0; i--)
      if (bus.req_i[i]) rr_idx = IdxWidth'(i);
    for (int i = NumPorts-1; i >= 0; i--)
      if (bus.req_i[i] && (i > int'(rr_q))) rr_idx = IdxWidth'(i);
  end

  assign lock_hit = lock_q & bus.req_i[lock_idx_q];
  assign win_idx  = lock_hit ? lock_idx_q : rr_idx;
  assign mem_req  = |bus.req_i;
  assign xfer     = mem_req & bus.mem_gnt_i;

  assign bus.mem_req_o   = mem_req;
  assign bus.idx_o       = win_idx;
  assign bus.mem_addr_o  = bus.addr_i[int'(win_idx)*AddrWidth +: AddrWidth];
  assign bus.mem_we_o    = bus.we_i[win_idx];
  assign bus.mem_wdata_o = bus.wdata_i[int'(win_idx)*DataWidth +: DataWidth];
  assign bus.mem_be_o    = bus.be_i[int'(win_idx)*BeWidth +: BeWidth];
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;

  always_comb begin
    gnt    = '0;
    rvalid = '0;
    for (int i = 0; i < NumPorts; i++) begin
      gnt[i]    = xfer && (win_idx == IdxWidth'(i));
      rvalid[i] = rsp_out.valid && (rsp_out.idx == rsp_idx_t'(i));
    end
  end

  // A stalled offer locks; a transfer or the locked port withdrawing releases it.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = mem_req & ~bus.mem_gnt_i;
    lock_idx_d = lock_idx_q;
    if (xfer) rr_d = win_idx;
    if (lock_d) lock_idx_d = win_idx;
    if (flush_i) begin
      rr_d   = LastIdx;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= LastIdx;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign rsp_in = '{valid: xfer, idx: rsp_idx_t'(win_idx)};

  mem_port_arb_rsp_pipe #(
    .Latency (MemLatency)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stage_i (rsp_in),
    .stage_o (rsp_out)
  );

`ifdef MEM_PORT_ARB_PERF_CNT_EN
  logic [PerfCntWidth-1:0] cnt_q [NumPorts];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumPorts; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++)
        if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NumPorts; g++) begin : g_cnt
    assign grant_cnt_o[g*PerfCntWidth +: PerfCntWidth] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MemLatency 1 and 3) driven in lockstep from one vector table.
module tb_mem_port_arbiter;
  import mem_port_arb_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic          fl;
    logic [NP-1:0] req;
    logic          mg;
    logic [NP-1:0] eg;
    logic [1:0]    ei;
  } vec_t;

  typedef struct {
    int due;
    int port;
  } exp_rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];
  logic [BW-1:0] p_be    [NP];
  logic [NP-1:0] p_we;
  logic [DW-1:0] rdata_v;

  exp_rsp_t sb1[$];
  exp_rsp_t sb3[$];
  vec_t     tv[31];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_port_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus1 ();
  mem_port_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus3 ();

`ifdef MEM_PORT_ARB_PERF_CNT_EN
  logic [NP*PerfCntWidth-1:0] cnt1, cnt3;
`endif

  mem_port_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MemLatency(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus1)
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    ,
    .grant_cnt_o (cnt1)
`endif
  );

  mem_port_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MemLatency(3)) dut3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus3)
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    ,
    .grant_cnt_o (cnt3)
`endif
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [NP-1:0] req, input logic mg, input logic fl);
    logic [NP*AW-1:0] a;
    logic [NP*DW-1:0] w;
    logic [NP*BW-1:0] b;
    for (int k = 0; k < NP; k++) begin
      p_addr[k]  = $urandom;
      p_wdata[k] = $urandom;
      p_be[k]    = BW'($urandom_range(0, 15));
      a[k*AW +: AW] = p_addr[k];
      w[k*DW +: DW] = p_wdata[k];
      b[k*BW +: BW] = p_be[k];
    end
    p_we    = NP'($urandom_range(0, 15));
    rdata_v = $urandom;
    flush   = fl;
    bus1.req_i = req;  bus1.mem_gnt_i = mg;  bus1.addr_i = a;  bus1.wdata_i = w;
    bus1.be_i  = b;    bus1.we_i = p_we;     bus1.mem_rdata_i = rdata_v;
    bus3.req_i = req;  bus3.mem_gnt_i = mg;  bus3.addr_i = a;  bus3.wdata_i = w;
    bus3.be_i  = b;    bus3.we_i = p_we;     bus3.mem_rdata_i = rdata_v;
  endtask

  task automatic check_rsp(input string nm, input int lat);
    exp_rsp_t      h;
    logic [NP-1:0] act, ev;
    logic [DW-1:0] rd;
    bit            have;
    have = 1'b0;
    if (lat == 1) begin
      act = bus1.rvalid_o;
      rd  = bus1.rdata_o;
      if (sb1.size() > 0 && sb1[0].due == cyc) begin h = sb1.pop_front(); have = 1'b1; end
    end else begin
      act = bus3.rvalid_o;
      rd  = bus3.rdata_o;
      if (sb3.size() > 0 && sb3[0].due == cyc) begin h = sb3.pop_front(); have = 1'b1; end
    end
    ev = '0;
    if (have) ev[h.port] = 1'b1;
    cmp({nm, ".rvalid"}, 64'(act), 64'(ev));
    if (have) cmp({nm, ".rdata"}, 64'(rd), 64'(rdata_v));
  endtask

  task automatic check_cycle(input string nm, input logic [NP-1:0] eg, input logic [1:0] ei, input logic er);
    cmp({nm, ".gnt1"}, 64'(bus1.gnt_o), 64'(eg));
    cmp({nm, ".gnt3"}, 64'(bus3.gnt_o), 64'(eg));
    cmp({nm, ".idx1"}, 64'(bus1.idx_o), 64'(ei));
    cmp({nm, ".idx3"}, 64'(bus3.idx_o), 64'(ei));
    cmp({nm, ".mreq"}, 64'(bus1.mem_req_o), 64'(er));
    if (er) begin
      cmp({nm, ".addr"},  64'(bus1.mem_addr_o),  64'(p_addr[ei]));
      cmp({nm, ".we"},    64'(bus1.mem_we_o),    64'(p_we[ei]));
      cmp({nm, ".wdata"}, 64'(bus1.mem_wdata_o), 64'(p_wdata[ei]));
      cmp({nm, ".be"},    64'(bus1.mem_be_o),    64'(p_be[ei]));
    end
    check_rsp({nm, ".L1"}, 1);
    check_rsp({nm, ".L3"}, 3);
    if (eg != '0) begin
      sb1.push_back('{due: cyc + 1, port: int'(ei)});
      sb3.push_back('{due: cyc + 3, port: int'(ei)});
    end
  endtask

  initial begin
    //             fl    req      mg    gnt      idx
    tv[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0};
    tv[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1};
    tv[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2};
    tv[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3};
    tv[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0};
    tv[5]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1};
    tv[6]  = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3};
    tv[7]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1};
    tv[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2};
    tv[9]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1};
    tv[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2};
    tv[11] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2};
    tv[12] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 2'd2};
    tv[13] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 2'd2};
    tv[14] = '{1'b0, 4'b0101, 1'b1, 4'b0100, 2'd2};
    tv[15] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 2'd0};
    tv[16] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0};
    tv[17] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd3};
    tv[18] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1};
    tv[19] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd3};
    tv[20] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 2'd3};
    tv[21] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0};
    tv[22] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3};
    tv[23] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
    tv[24] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
    tv[25] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
    tv[26] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1};
    tv[27] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1};
    tv[28] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
    tv[29] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};
    tv[30] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};

    drive('0, 1'b0, 1'b0);
    #2;
    cmp("rst.rvalid1", 64'(bus1.rvalid_o), 64'(0));
    cmp("rst.rvalid3", 64'(bus3.rvalid_o), 64'(0));
    cmp("rst.gnt1",    64'(bus1.gnt_o),    64'(0));
    cmp("rst.idx1",    64'(bus1.idx_o),    64'(0));
    cmp("rst.mreq1",   64'(bus1.mem_req_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      @(posedge clk); #1;
      drive(tv[i].req, tv[i].mg, tv[i].fl);
      @(negedge clk);
      check_cycle($sformatf("v%0d", i), tv[i].eg, tv[i].ei, |tv[i].req);
    end

    // Reset with responses in flight in both instances.
    @(posedge clk); #1;
    drive(4'b0010, 1'b1, 1'b0);
    @(negedge clk);
    check_cycle("rs0", 4'b0010, 2'd1, 1'b1);
    @(posedge clk); #1;
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    check_cycle("rs1", 4'b0000, 2'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    cmp("rs.rvalid1", 64'(bus1.rvalid_o), 64'(0));
    cmp("rs.rvalid3", 64'(bus3.rvalid_o), 64'(0));
    sb1.delete();
    sb3.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive('0, 1'b0, 1'b0);
      @(negedge clk);
      check_cycle($sformatf("rsidle%0d", i), 4'b0000, 2'd0, 1'b0);
    end
    @(posedge clk); #1;
    drive(4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    check_cycle("rs_rr", 4'b0001, 2'd0, 1'b1);

`ifdef MEM_PORT_ARB_PERF_CNT_EN
    for (int i = 0; i < 65533; i++) begin
      @(posedge clk); #1;
      drive(4'b0001, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    cmp("cnt.p0_fffe", 64'(cnt1[PerfCntWidth-1:0]), 64'(16'hFFFE));
    cmp("cnt.p1_zero", 64'(cnt1[2*PerfCntWidth-1:PerfCntWidth]), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(4'b0001, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    cmp("cnt.p0_sat1", 64'(cnt1[PerfCntWidth-1:0]), 64'(16'hFFFF));
    cmp("cnt.p0_sat3", 64'(cnt3[PerfCntWidth-1:0]), 64'(16'hFFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported SRAM request interface among NumPorts requesters using fair round-robin arbitration.
- Holds the grant on a stalled request: once offered to memory, the chosen port stays selected until memory accepts it.
- Routes each response back to its originating port after a fixed memory read latency.
- Sits between the AXI-to-memory request splitters and the memory macro wrapper.

Parameters:
- NumPorts, 4, number of requesters (>=2).
- AddrWidth, 32, address width per port.
- DataWidth, 32, data width; byte-enable width = DataWidth/8.
- MemLatency, 1, cycles from memory handshake to rdata valid (>=1).
- IdxWidth, $clog2(NumPorts), port index width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of arbitration state.
- req_i  in  NumPorts  per-port request valid.
- gnt_o  out  NumPorts  per-port grant (one-hot or zero).
- addr_i  in  NumPorts*AddrWidth  per-port address, packed with port 0 in the LSBs.
- we_i  in  NumPorts  per-port write enable.
- wdata_i  in  NumPorts*DataWidth  per-port write data.
- be_i  in  NumPorts*DataWidth/8  per-port byte enables.
- rvalid_o  out  NumPorts  per-port response valid.
- rdata_o  out  DataWidth  response data, broadcast to all ports.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accept.
- mem_addr_o / mem_we_o / mem_wdata_o / mem_be_o  out  AddrWidth / 1 / DataWidth / DataWidth/8  selected port's payload.
- mem_rdata_i  in  DataWidth  memory read data.
- idx_o  out  IdxWidth  currently selected port.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset state:
  - rr_q = NumPorts-1, so port 0 has highest priority first.
  - lock_q = 0.
  - Response pipe empty; rvalid_o = 0.
- Request path:
  - Combinational; 0-cycle latency from req_i to mem_req_o.
  - mem_req_o = |req_i.
  - Payload muxed from winner; idx_o = winner. idx_o = 0 when no request is present.
- Winner selection when unlocked: lowest-index requesting port with index > rr_q; otherwise lowest-index requesting port <= rr_q.
- Transfer = mem_req_o & mem_gnt_i. On transfer:
  - gnt_o[winner] = 1, all other grants 0.
  - rr_q <= winner.
  - Transfer is pushed into the response pipe.
- Grant gating: gnt_o is always 0 when mem_gnt_i = 0 or there is no request.
- Lock:
  - If mem_req_o & ~mem_gnt_i, then lock_q <= 1 and lock_idx_q <= winner.
  - While lock_q is set, winner = lock_idx_q regardless of other requests, and payload is taken from that port.
  - lock_q clears on transfer.
  - Locked port dropping req_i is a protocol violation; the lock clears that same cycle and arbitration falls back to normal selection.
- Response pipe:
  - MemLatency-deep shift register of {valid, idx}, stage 0 written on transfer.
  - rvalid_o[idx] = last-stage valid. Writes also return rvalid.
  - rdata_o = mem_rdata_i directly; it is don't-care when no rvalid is asserted.
  - Pipe fills and drains at full rate: one transfer per cycle, no backpressure.
- flush_i clears rr_q to NumPorts-1 and clears lock_q. It does not clear the response pipe; in-flight responses are still delivered. flush_i has priority over a same-cycle rr/lock update.
- Reset mid-operation drops all in-flight responses; rvalid_o goes low asynchronously.
- Simultaneous requests from all ports are served in rotation: each port is granted at most once per NumPorts transfers.

Optional Feature:
- Macro MEM_PORT_ARB_PERF_CNT_EN.
- When defined:
  - Adds output grant_cnt_o, NumPorts*16, one counter per port.
  - Counter increments on that port's transfer and saturates at 16'hFFFF.
  - Cleared by rst_i; not cleared by flush_i.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_port_arb_pkg holds:
  - IdxWidth computation function.
  - rsp_stage_t struct {valid, idx}.
  - Counter width constant PerfCntWidth = 16.
- Sub-module mem_port_arb_rsp_pipe: parameterised latency delay line of rsp_stage_t with async active-high reset.
- Winner selection stays inline.

Test Plan:
- Reset, then req_i=4'b1111 with mem_gnt_i=1 held → grants in order 0,1,2,3,0; each rvalid_o[k] one cycle after its grant (MemLatency=1).
- req_i=4'b1010, rr_q=1 → port 3 granted; next cycle port 1 granted.
- req_i[2]=1 with mem_gnt_i=0 for 3 cycles, port 0 requests in cycle 2 → idx_o stays 2; on mem_gnt_i=1, gnt_o=4'b0100.
- MemLatency=3, back-to-back grants to ports 1,2,1 → rvalid_o pulses 3 cycles later, in order 1,2,1, with mem_rdata_i passed through unchanged.
- flush_i while a read is in flight and lock is active → lock cleared, next grant goes to port 0, in-flight rvalid still delivered. rst_i asserted mid-flight → rvalid_o=0 immediately.
- With MEM_PORT_ARB_PERF_CNT_EN, preload port 0's counter to 16'hFFFE, then apply 3 grants to port 0 → counter reads 16'hFFFF and holds.
